// File: rtl/load_store_unit_pkg.sv
// Shared rv32i LSU definitions: access-size encodings (as driven by the decoder on B_H_W),
// LSU state encodings and the store-side lane helpers.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    // Misaligned halves/words and the reserved size never reach the bus.
    function automatic logic access_fault(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_WORD: return addr_lo != 2'b00;
            SIZE_HALF: return addr_lo[0];
            SIZE_BYTE: return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return 4'b0011 << addr_lo;
            default:   return 4'b1111;
        endcase
    endfunction

    // Replicating the narrow datum lets memory pick it up from whichever lane is enabled.
    function automatic logic [31:0] store_data(input lsu_size_e size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide req/ack data-memory bus between the LSU (master) and data memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load formatter: picks the addressed byte/half out of a memory word and sign/zero-extends it.
// Purely combinational so a cache read path can share it.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  lsu_size_e   size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Halves are always aligned here, so only addr_lo[1] selects the half lane.
    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: default first so every path assigns result and no latch is inferred.
        result = rdata;
        case (size)
            SIZE_BYTE: result = {{24{sign & byte_lane[7]}}, byte_lane};
            SIZE_HALF: result = {{16{sign & half_lane[15]}}, half_lane};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX and data memory: one request at a time, req/ack bus handshake,
// store lane steering, load formatting and a bus timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_sign,
    input  logic [31:0]       lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic [31:0]       lsu_rdata,
    load_store_unit_if.master mem
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e       state;
    lsu_size_e        cap_size;
    logic             cap_sign;
    logic             cap_we;
    logic [1:0]       cap_addr_lo;
    logic [CNT_W-1:0] tmo_cnt;
    logic [31:0]      load_result;
    logic             timeout_hit;

    // The counter only ever reaches TIMEOUT_CYCLES-1; the expiring cycle is detected one early.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_load_align u_load_align (
        .rdata   (mem.mem_rdata),
        .addr_lo (cap_addr_lo),
        .size    (cap_size),
        .sign    (cap_sign),
        .result  (load_result)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cap_size      <= SIZE_WORD;
            cap_sign      <= 1'b0;
            cap_we        <= 1'b0;
            cap_addr_lo   <= 2'b00;
            tmo_cnt       <= '0;
            lsu_busy      <= 1'b0;
            lsu_done      <= 1'b0;
            lsu_err       <= 1'b0;
            lsu_rdata     <= 32'h0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_be    <= 4'h0;
            mem.mem_wdata <= 32'h0;
        end else begin
            lsu_done <= 1'b0;
            lsu_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (lsu_req) begin
                        cap_we      <= lsu_we;
                        cap_size    <= lsu_size_e'(lsu_size);
                        cap_sign    <= lsu_sign;
                        cap_addr_lo <= lsu_addr[1:0];
                        lsu_busy    <= 1'b1;
                        if (access_fault(lsu_size_e'(lsu_size), lsu_addr[1:0])) begin
                            state    <= ST_RESP;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b1;
                        end else begin
                            state         <= ST_BUS;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= lsu_we;
                            mem.mem_addr  <= {lsu_addr[31:2], 2'b00};
                            mem.mem_be    <= byte_enable(lsu_size_e'(lsu_size), lsu_addr[1:0]);
                            mem.mem_wdata <= store_data(lsu_size_e'(lsu_size), lsu_wdata);
                        end
                    end
                end
                ST_BUS: begin
                    // An ack in the expiring cycle still completes the access normally.
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (!cap_we) lsu_rdata <= load_result;
                        state    <= ST_RESP;
                        lsu_done <= 1'b1;
                    end else if (timeout_hit) begin
                        mem.mem_req <= 1'b0;
                        state    <= ST_RESP;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    lsu_busy <= 1'b0;
                    tmo_cnt  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
